// File: rtl/rr_stream_arbiter_if.sv
// rr_stream_arbiter_if: per-channel input streams plus the merged output stream of the arbiter
interface rr_stream_arbiter_if #(
  parameter int DW = 8,
  parameter int CH = 4,
  parameter int CW = $clog2(CH)
);
  logic [DW-1:0] in_data [CH];
  logic [CH-1:0] in_valid;
  logic [CH-1:0] in_last;
  logic [CH-1:0] in_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ch;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_ch, out_last, out_valid
  );
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_ch, out_last, out_valid
  );
endinterface

// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: round-robin merge of CH streams into one registered stream; define RR_ARB_PKT_LOCK_EN for packet lock
module rr_stream_arbiter #(
  parameter int DW = 8,
  parameter int CH = 4,
  parameter int CW = $clog2(CH)
) (
  input logic clk,
  input logic rst_n,
  rr_stream_arbiter_if.slave bus
);
  logic [CW-1:0] r_ptr;
  logic [DW-1:0] r_out_data;
  logic [CW-1:0] r_out_ch;
  logic          r_out_last;
  logic          r_out_valid;
  logic          w_load;
  logic          w_any;
  logic [CW-1:0] w_win;
  logic [CH-1:0] w_elig;
`ifdef RR_ARB_PKT_LOCK_EN
  logic          r_locked;
  logic [CW-1:0] r_lock_ch;
  assign w_elig = r_locked ? (bus.in_valid & (CH'(1) << r_lock_ch)) : bus.in_valid;
`else
  assign w_elig = bus.in_valid;
`endif
  assign w_load = !r_out_valid || bus.out_ready;
  // no grant is issued while reset is held, so nothing is accepted and then dropped
  assign bus.in_ready  = (rst_n && w_load && w_any) ? (CH'(1) << w_win) : '0;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_last  = r_out_last;
  assign bus.out_valid = r_out_valid;
  // winner: first eligible channel scanning upward from ptr with wrap at CH
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = CH - 1; k >= 0; k--)
      if (w_elig[(int'(r_ptr) + k) % CH]) begin
        w_any = 1'b1;
        w_win = CW'((int'(r_ptr) + k) % CH);
      end
  end
  // output register, round-robin pointer and optional packet lock
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef RR_ARB_PKT_LOCK_EN
      r_locked    <= 1'b0;
      r_lock_ch   <= '0;
`endif
    end else if (w_load) begin
      r_out_valid <= w_any;
      if (w_any) begin
        r_out_data <= bus.in_data[w_win];
        r_out_ch   <= w_win;
        r_out_last <= bus.in_last[w_win];
`ifdef RR_ARB_PKT_LOCK_EN
        r_locked   <= !bus.in_last[w_win];
        r_lock_ch  <= w_win;
        if (bus.in_last[w_win]) r_ptr <= (w_win == CW'(CH - 1)) ? '0 : w_win + 1'b1;
`else
        r_ptr      <= (w_win == CW'(CH - 1)) ? '0 : w_win + 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_rr_stream_arbiter.sv
// tb_rr_stream_arbiter: directed table plus hand sequences for backpressure, lock and reset
module tb_rr_stream_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  rr_stream_arbiter_if #(.DW(8), .CH(4)) bus ();
  rr_stream_arbiter #(.DW(8), .CH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       r;
    logic [3:0] er;
    logic       eov;
    logic [1:0] ech;
    logic [7:0] ed;
    logic       el;
  } vec_t;
  vec_t tv [13];
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic beat(input string name, input logic [3:0] v, input logic [3:0] l, input logic r,
                      input logic [3:0] er, input logic eov, input logic [1:0] ech,
                      input logic [7:0] ed, input logic el);
    bus.in_valid  = v;
    bus.in_last   = l;
    bus.out_ready = r;
    #1;
    chk({name, " in_ready"}, int'(bus.in_ready), int'(er));
    @(posedge clk);
    #1;
    chk({name, " out_valid"}, int'(bus.out_valid), int'(eov));
    chk({name, " out_ch"}, int'(bus.out_ch), int'(ech));
    chk({name, " out_data"}, int'(bus.out_data), int'(ed));
    chk({name, " out_last"}, int'(bus.out_last), int'(el));
  endtask
  initial begin
    tv[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 1'b1};
    tv[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b1};
    tv[2]  = '{4'b0100, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12, 1'b1};
    tv[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13, 1'b1};
    tv[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 1'b1};
    tv[5]  = '{4'b1000, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13, 1'b1};
    tv[6]  = '{4'b0100, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12, 1'b1};
    tv[7]  = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h12, 1'b1};
    tv[8]  = '{4'b0001, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h10, 1'b1};
    tv[9]  = '{4'b0011, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h10, 1'b1};
    tv[10] = '{4'b0011, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b1};
    tv[11] = '{4'b0001, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 1'b1};
    tv[12] = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b1};
    for (int i = 0; i < 4; i++) bus.in_data[i] = 8'h10 + 8'(i);
    bus.in_valid  = 4'b1111;
    bus.in_last   = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    chk("reset in_ready", int'(bus.in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset out_ch", int'(bus.out_ch), 0);
    chk("reset out_data", int'(bus.out_data), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++)
      beat($sformatf("vec%0d", i), tv[i].v, tv[i].l, tv[i].r, tv[i].er, tv[i].eov, tv[i].ech, tv[i].ed, tv[i].el);
    bus.in_data[2] = 8'hA5;
    beat("bp load", 4'b0100, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5, 1'b1);
    for (int i = 0; i < 3; i++)
      beat($sformatf("bp hold%0d", i), 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5, 1'b1);
    beat("bp release", 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13, 1'b1);
    bus.in_data[2] = 8'h12;
    beat("lk pre", 4'b0001, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 1'b1);
`ifdef RR_ARB_PKT_LOCK_EN
    beat("lk c1", 4'b0111, 4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b0);
    beat("lk c2", 4'b0111, 4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b0);
    beat("lk c3", 4'b0111, 4'b0111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b1);
    beat("lk c4", 4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12, 1'b1);
    beat("lk c5", 4'b0101, 4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 1'b1);
`else
    beat("lk c1", 4'b0111, 4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b0);
    beat("lk c2", 4'b0111, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12, 1'b1);
    beat("lk c3", 4'b0111, 4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 1'b1);
    beat("lk c4", 4'b0111, 4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b0);
    beat("lk c5", 4'b0111, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12, 1'b1);
`endif
    rst_n = 1'b0;
    bus.in_valid  = 4'b0001;
    bus.in_last   = 4'b1111;
    bus.out_ready = 1'b0;
    #1;
    chk("mid reset in_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    chk("mid reset out_valid", int'(bus.out_valid), 0);
    chk("mid reset out_ch", int'(bus.out_ch), 0);
    chk("mid reset out_data", int'(bus.out_data), 0);
    chk("mid reset out_last", int'(bus.out_last), 0);
    rst_n = 1'b1;
    beat("post reset ptr0", 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
